acc_cpu_core: RTL and testbench

Parametrised multi-cycle accumulator CPU core: the successor to the fixed 8-bit decoder/executor pair. It fetches instructions over a request/acknowledge port, and decodes a 4-bit opcode plus operand address. It executes against an accumulator with Z/C flags, accesses data memory through a separate request/acknowledge port, and drives a valid/ready output channel. The core sits between the board-level top, instruction ROM and data RAM, replacing the separate decoder and executor.

---
 rtl/cpu_pkg.sv | 44 ++++
 rtl/cpu_alu.sv | 50 +++++
 rtl/acc_cpu_core.sv | 135 +++++++++++++
 tb/tb_acc_cpu_core.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator core: opcode map, FSM states
// and ALU select codes.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_JC  = 4'hB;
    localparam logic [3:0] OP_OUT = 4'hC;
    localparam logic [3:0] OP_SHL = 4'hD;
    localparam logic [3:0] OP_SHR = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_MEM, ST_EXEC, ST_OUTW, ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_PASS, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR
    } alu_op_t;

    // PASS forwards b and keeps C, which covers LDA and LDI.
    function automatic alu_op_t alu_sel(input logic [3:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_XOR:  return ALU_XOR;
            OP_SHL:  return ALU_SHL;
            OP_SHR:  return ALU_SHR;
            default: return ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: result plus Z, and C either computed or passed through.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    input  logic              c_in,
    output logic [DATA_W-1:0] result,
    output logic              z,
    output logic              c
);

    logic [DATA_W:0] ext;

    always_comb begin
        ext    = '0;
        result = b;
        c      = c_in;
        case (op)
            ALU_ADD: begin
                ext    = {1'b0, a} + {1'b0, b};
                result = ext[DATA_W-1:0];
                c      = ext[DATA_W];
            end
            // top bit of the widened difference is the borrow
            ALU_SUB: begin
                ext    = {1'b0, a} - {1'b0, b};
                result = ext[DATA_W-1:0];
                c      = ext[DATA_W];
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SHL: begin
                result = {a[DATA_W-2:0], 1'b0};
                c      = a[DATA_W-1];
            end
            ALU_SHR: begin
                result = {1'b0, a[DATA_W-1:1]};
                c      = a[0];
            end
            default: ;
        endcase
        z = (result == '0);
    end

endmodule

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator core: fetch/decode FSM, pc, ir, accumulator and
// Z/C flags, with req/ack instruction and data ports and a valid/ready output.
module acc_cpu_core
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int PC_W   = 8,
    parameter int OP_W   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [PC_W-1:0]        imem_addr,
    input  logic                   imem_ack,
    input  logic [OP_W+ADDR_W-1:0] imem_data,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic [ADDR_W-1:0]      dmem_addr,
    output logic [DATA_W-1:0]      dmem_wdata,
    input  logic [DATA_W-1:0]      dmem_rdata,
    input  logic                   dmem_ack,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   halted,
    output logic [DATA_W-1:0]      acc
);

    localparam int IR_W = OP_W + ADDR_W;

    state_t              state_q;
    logic [PC_W-1:0]     pc_q;
    logic [IR_W-1:0]     ir_q;
    logic [DATA_W-1:0]   acc_q, mdr_q, out_q;
    logic                z_q, c_q;

    logic [OP_W-1:0]     ir_op;
    logic [ADDR_W-1:0]   ir_k;
    logic [31:0]         op_ext;
    logic [3:0]          opc;
    logic [PC_W-1:0]     jmp_tgt;
    logic [DATA_W-1:0]   alu_b, alu_res;
    logic                alu_z, alu_c;

    assign ir_op   = ir_q[IR_W-1 -: OP_W];
    assign ir_k    = ir_q[ADDR_W-1:0];
    // opcodes beyond the 4-bit map behave as NOP
    assign op_ext  = 32'(ir_op);
    assign opc     = (op_ext[31:4] == '0) ? op_ext[3:0] : OP_NOP;
    assign jmp_tgt = PC_W'(ir_k);
    assign alu_b   = (state_q == ST_EXEC) ? mdr_q : DATA_W'(ir_k);

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (acc_q),
        .b      (alu_b),
        .op     (alu_sel(opc)),
        .c_in   (c_q),
        .result (alu_res),
        .z      (alu_z),
        .c      (alu_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            acc_q   <= '0;
            mdr_q   <= '0;
            out_q   <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: if (imem_ack) begin
                    ir_q    <= imem_data;
                    pc_q    <= pc_q + PC_W'(1);
                    state_q <= ST_DECODE;
                end
                ST_DECODE: begin
                    state_q <= ST_FETCH;
                    case (opc)
                        OP_LDA, OP_STA, OP_ADD, OP_SUB,
                        OP_AND, OP_OR, OP_XOR: state_q <= ST_MEM;
                        OP_OUT: begin
                            out_q   <= acc_q;
                            state_q <= ST_OUTW;
                        end
                        OP_HLT: state_q <= ST_HALT;
                        OP_JMP: pc_q <= jmp_tgt;
                        OP_JZ:  if (z_q) pc_q <= jmp_tgt;
                        OP_JC:  if (c_q) pc_q <= jmp_tgt;
                        OP_LDI, OP_SHL, OP_SHR: begin
                            acc_q <= alu_res;
                            z_q   <= alu_z;
                            c_q   <= alu_c;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: if (dmem_ack) begin
                    if (opc == OP_STA) begin
                        state_q <= ST_FETCH;
                    end else begin
                        mdr_q   <= dmem_rdata;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    acc_q   <= alu_res;
                    z_q     <= alu_z;
                    c_q     <= alu_c;
                    state_q <= ST_FETCH;
                end
                ST_OUTW: if (out_ready) state_q <= ST_FETCH;
                ST_HALT: ;
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    // Requests decode straight from the state so reset drops them at once.
    assign imem_req   = (state_q == ST_FETCH) && !reset;
    assign imem_addr  = pc_q;
    assign dmem_req   = (state_q == ST_MEM);
    assign dmem_we    = dmem_req && (opc == OP_STA);
    assign dmem_addr  = ir_k;
    assign dmem_wdata = acc_q;
    assign out_data   = out_q;
    assign out_valid  = (state_q == ST_OUTW);
    assign halted     = (state_q == ST_HALT);
    assign acc        = acc_q;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed bench for acc_cpu_core: table of single-instruction vectors with
// flags exposed through jump paths, plus handshake/timing/reset sequences.
module tb_acc_cpu_core;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
    logic [7:0]  imem_addr, dmem_addr, dmem_wdata, dmem_rdata, out_data, acc;
    logic [11:0] imem_data;
    logic        out_valid, out_ready = 1'b1, halted;

    logic        imem_req16, imem_ack16, dmem_req16, dmem_we16, out_valid16, halted16;
    logic [9:0]  imem_addr16, dmem_addr16;
    logic [13:0] imem_data16;
    logic [15:0] dmem_wdata16, out_data16, acc16;

    logic [11:0] rom [256];
    logic [7:0]  ram [256];
    logic [13:0] rom16 [1024];

    int iwait = 0, dwait = 0, icnt, dcnt, cyc = 0;
    int nf, f_cyc [64];
    logic [7:0] f_addr [64];
    int dreq_cyc, unstable;
    logic        d_pend;
    logic [16:0] d_prev;
    logic [7:0]  wr_addr, wr_data;
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    acc_cpu_core dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .halted(halted), .acc(acc)
    );

    acc_cpu_core #(.DATA_W(16), .ADDR_W(10), .PC_W(10), .OP_W(4)) dut16 (
        .clk(clk), .reset(reset),
        .imem_req(imem_req16), .imem_addr(imem_addr16), .imem_ack(imem_ack16), .imem_data(imem_data16),
        .dmem_req(dmem_req16), .dmem_we(dmem_we16), .dmem_addr(dmem_addr16), .dmem_wdata(dmem_wdata16),
        .dmem_rdata(16'h0000), .dmem_ack(dmem_req16),
        .out_data(out_data16), .out_valid(out_valid16), .out_ready(1'b1),
        .halted(halted16), .acc(acc16)
    );

    assign imem_ack    = imem_req && (icnt >= iwait);
    assign imem_data   = rom[imem_addr];
    assign dmem_ack    = dmem_req && (dcnt >= dwait);
    assign dmem_rdata  = ram[dmem_addr];
    assign imem_ack16  = imem_req16;
    assign imem_data16 = rom16[imem_addr16];

    always @(posedge clk) cyc <= cyc + 1;

    // wait-state counters, fetch log, data-port stability monitor
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            icnt <= 0; dcnt <= 0; nf <= 0; dreq_cyc <= 0; unstable <= 0; d_pend <= 1'b0;
            d_prev <= '0; wr_addr <= '0; wr_data <= '0;
        end else begin
            icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
            dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
            if (imem_req && imem_ack && nf < 64) begin
                f_cyc[nf]  <= cyc;
                f_addr[nf] <= imem_addr;
                nf         <= nf + 1;
            end
            if (dmem_req) begin
                dreq_cyc <= dreq_cyc + 1;
                if (d_pend && {dmem_addr, dmem_we, dmem_wdata} != d_prev) unstable <= unstable + 1;
            end
            if (dmem_req && dmem_ack && dmem_we) begin
                wr_addr <= dmem_addr;
                wr_data <= dmem_wdata;
            end
            d_pend <= dmem_req && !dmem_ack;
            d_prev <= {dmem_addr, dmem_we, dmem_wdata};
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [11:0] ins(input logic [3:0] op, input logic [7:0] k);
        return {op, k};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            rom[i] = ins(OP_HLT, 8'h00);
            ram[i] = 8'h00;
        end
    endtask

    task automatic do_reset(input bit check);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        if (check) begin
            chk("rst_imem_req", imem_req, 0);
            chk("rst_dmem_req", dmem_req, 0);
            chk("rst_dmem_we", dmem_we, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_halted", halted, 0);
            chk("rst_acc", acc, 0);
            chk("rst_pc", imem_addr, 0);
        end
        reset = 1'b0;
        #1;
        if (check) chk("req_after_rst", imem_req, 1);
    endtask

    task automatic wait_halt(input string nm, input int max);
        int n = 0;
        while (!halted && n < max) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_halted"}, halted, 1);
    endtask

    typedef struct {
        logic [3:0] op;
        logic [7:0] k;
        logic [7:0] pre;
        logic [7:0] mval;
        logic [7:0] exp_acc;
        logic       exp_z;
        logic       exp_c;
    } vec_t;

    vec_t vt [13];

    initial begin
        vt[0]  = '{OP_ADD, 8'h03, 8'd5,   8'd250, 8'd255, 1'b0, 1'b0};
        vt[1]  = '{OP_ADD, 8'h04, 8'd255, 8'd1,   8'd0,   1'b1, 1'b1};
        vt[2]  = '{OP_SUB, 8'h05, 8'd3,   8'd5,   8'd254, 1'b0, 1'b1};
        vt[3]  = '{OP_SUB, 8'h05, 8'd5,   8'd5,   8'd0,   1'b1, 1'b0};
        vt[4]  = '{OP_AND, 8'h06, 8'hF0,  8'h3C,  8'h30,  1'b0, 1'b0};
        vt[5]  = '{OP_OR,  8'h07, 8'h00,  8'h00,  8'h00,  1'b1, 1'b0};
        vt[6]  = '{OP_XOR, 8'h08, 8'hFF,  8'hFF,  8'h00,  1'b1, 1'b0};
        vt[7]  = '{OP_LDA, 8'h09, 8'd7,   8'h00,  8'h00,  1'b1, 1'b0};
        vt[8]  = '{OP_SHL, 8'h00, 8'h81,  8'h00,  8'h02,  1'b0, 1'b1};
        vt[9]  = '{OP_SHR, 8'h00, 8'h01,  8'h00,  8'h00,  1'b1, 1'b1};
        vt[10] = '{OP_LDI, 8'h00, 8'd9,   8'h00,  8'h00,  1'b1, 1'b0};
        vt[11] = '{OP_NOP, 8'h00, 8'd4,   8'h00,  8'd4,   1'b0, 1'b0};
        vt[12] = '{OP_STA, 8'h10, 8'h5A,  8'h00,  8'h5A,  1'b0, 1'b0};

        for (int i = 0; i < 1024; i++) rom16[i] = 14'h3C00;
        rom16[0] = {OP_LDI, 10'h3FF};

        clear_mem();
        do_reset(1'b1);

        // Vectors: Z/C steer the halt point via JZ then JC.
        for (int i = 0; i < 13; i++) begin
            logic [7:0] exp_pc;
            clear_mem();
            rom[0]     = ins(OP_LDI, vt[i].pre);
            rom[1]     = ins(vt[i].op, vt[i].k);
            rom[2]     = ins(OP_JZ, 8'h10);
            rom[3]     = ins(OP_JC, 8'h20);
            rom[8'h10] = ins(OP_JC, 8'h30);
            ram[vt[i].k] = vt[i].mval;
            exp_pc = vt[i].exp_z ? (vt[i].exp_c ? 8'h31 : 8'h12) : (vt[i].exp_c ? 8'h21 : 8'h05);
            do_reset(1'b0);
            wait_halt($sformatf("v%0d", i), 100);
            chk($sformatf("v%0d_acc", i), acc, vt[i].exp_acc);
            chk($sformatf("v%0d_flags_pc", i), imem_addr, exp_pc);
            if (vt[i].op == OP_STA) chk("v_sta_wdata", {wr_addr, wr_data}, {8'h10, 8'h5A});
        end

        // Zero-wait instruction lengths, then HLT stays quiet.
        clear_mem();
        rom[0] = ins(OP_NOP, 8'h00);
        rom[1] = ins(OP_STA, 8'h10);
        rom[2] = ins(OP_LDA, 8'h03);
        rom[3] = ins(OP_OUT, 8'h00);
        do_reset(1'b0);
        wait_halt("len", 100);
        chk("len_nop", f_cyc[1] - f_cyc[0], 2);
        chk("len_sta", f_cyc[2] - f_cyc[1], 3);
        chk("len_lda", f_cyc[3] - f_cyc[2], 4);
        chk("len_out", f_cyc[4] - f_cyc[3], 3);
        begin
            int bad = 0;
            repeat (20) begin
                @(negedge clk);
                if (imem_req || !halted) bad++;
            end
            chk("halt_absorbing", bad, 0);
            chk("halt_fetches", nf, 5);
        end

        // STA with three dmem wait cycles.
        clear_mem();
        rom[0] = ins(OP_LDI, 8'h77);
        rom[1] = ins(OP_STA, 8'h10);
        dwait = 3;
        do_reset(1'b0);
        wait_halt("sta_wait", 100);
        chk("sta_wait_len", f_cyc[2] - f_cyc[1], 6);
        chk("sta_wait_req_cycles", dreq_cyc, 4);
        chk("sta_wait_stable", unstable, 0);
        chk("sta_wait_write", {wr_addr, wr_data}, {8'h10, 8'h77});
        dwait = 0;

        // OUT with sink stalled for five cycles.
        clear_mem();
        rom[0] = ins(OP_LDI, 8'h42);
        rom[1] = ins(OP_OUT, 8'h00);
        out_ready = 1'b0;
        do_reset(1'b0);
        begin
            int n = 0, bad = 0;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("out_seen", out_valid, 1);
            repeat (5) begin
                if (!out_valid || out_data != 8'h42 || imem_req) bad++;
                @(negedge clk);
            end
            chk("out_hold", bad, 0);
            chk("out_data_last", out_data, 8'h42);
            out_ready = 1'b1;
            @(negedge clk);
            chk("out_valid_drop", out_valid, 0);
        end
        wait_halt("out", 50);
        chk("out_len", f_cyc[2] - f_cyc[1], 8);

        // pc wraps from 0xFF to 0x00.
        clear_mem();
        rom[0]     = ins(OP_JMP, 8'hFF);
        rom[8'hFF] = ins(OP_NOP, 8'h00);
        do_reset(1'b0);
        repeat (12) @(negedge clk);
        chk("wrap_jmp", f_addr[1], 8'hFF);
        chk("wrap_pc0", f_addr[2], 8'h00);

        // Reset while MEM waits on a slow ack.
        clear_mem();
        rom[0] = ins(OP_LDI, 8'h33);
        rom[1] = ins(OP_LDA, 8'h05);
        dwait = 1000;
        do_reset(1'b0);
        begin
            int n = 0;
            while (!dmem_req && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("mrst_in_mem", dmem_req, 1);
            chk("mrst_acc_before", acc, 8'h33);
            reset = 1'b1;
            #1;
            chk("mrst_dmem_req", dmem_req, 0);
            chk("mrst_imem_req", imem_req, 0);
            chk("mrst_acc", acc, 0);
            chk("mrst_pc", imem_addr, 0);
            dwait = 0;
            repeat (2) @(negedge clk);
            reset = 1'b0;
            #1;
            chk("mrst_refetch", imem_req, 1);
        end

        repeat (10) @(negedge clk);
        chk("w16_halted", halted16, 1);
        chk("w16_acc", acc16, 16'h03FF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
